// File: rtl/io_timer_intc.sv
// io_timer_intc: memory-mapped down-counting timer with a level interrupt.
//
// The CPU reads and writes four 32-bit registers over the shared I/O bus.
// A prescaler divides clk into counter ticks. When the counter reaches its
// terminal count it sets PEND (and OVR if PEND was already set). intr follows
// PEND & IE one cycle later. The CPU releases intr by pulsing inta.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   io_cs      I/O chip select
//   io_rd      read strobe (combinational read onto io_out)
//   io_wr      write strobe (commits at rising clk)
//   io_address byte address: [31:4] block select, [3:2] register select
//   io_d_in    write data
//   io_out     read data, 0 when this block is not being read
//   intr       registered interrupt request
//   inta       interrupt acknowledge
//
// Register map: 0x0 CTRL {IE,AUTO,EN}, 0x4 LOAD, 0x8 COUNT, 0xC STATUS {OVR,PEND}.
module io_timer_intc #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_address,
  input  logic [31:0] io_d_in,
  output logic [31:0] io_out,
  output logic        intr,
  input  logic        inta
);

  localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        intr_q, intr_d;
  logic [15:0] presc_q, presc_d;

  logic sel, wr_ctrl, wr_load, wr_count, wr_status;
  logic en, auto_rl, ie;
  logic tick, term_evt, clr_pend;
  logic unused_addr;

  assign unused_addr = ^io_address[1:0];

  assign en      = ctrl_q[0];
  assign auto_rl = ctrl_q[1];
  assign ie      = ctrl_q[2];

  assign sel       = io_cs & (io_address[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl   = sel & io_wr & (io_address[3:2] == 2'd0);
  assign wr_load   = sel & io_wr & (io_address[3:2] == 2'd1);
  assign wr_count  = sel & io_wr & (io_address[3:2] == 2'd2);
  assign wr_status = sel & io_wr & (io_address[3:2] == 2'd3);

  assign tick     = en & (presc_q == PresLast);
  // Terminal when COUNT is 1 or 0 on a tick (0 covers a LOAD=0 reload).
  assign term_evt = tick & (count_q[31:1] == 31'd0);
  // Any source that consumes the current pending event this edge.
  assign clr_pend = (inta & intr_q) | (wr_status & io_d_in[0]);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    presc_d = presc_q;

    // Prescaler
    if (wr_ctrl || !en || tick) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    // Counter step; a one-shot terminal count also stops the timer
    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        count_d = auto_rl ? load_q : 32'd0;
      end
      if (term_evt && !auto_rl) begin
        ctrl_d[0] = 1'b0;
      end
    end

    // Status: event beats any clear of PEND on the same edge
    if (clr_pend) begin
      pend_d = 1'b0;
    end
    if (term_evt) begin
      pend_d = 1'b1;
      if (pend_q && !clr_pend) begin
        ovr_d = 1'b1;
      end
    end
    if (wr_status && io_d_in[1]) begin
      ovr_d = 1'b0;
    end

    // CPU writes take priority over timer activity
    if (wr_ctrl) begin
      ctrl_d = io_d_in[2:0];
    end
    if (wr_load) begin
      load_d = io_d_in;
    end
    if (wr_count) begin
      count_d = io_d_in;
    end

    intr_d = pend_q & ie;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      intr_q  <= 1'b0;
      presc_q <= 16'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      intr_q  <= intr_d;
      presc_q <= presc_d;
    end
  end

  assign intr = intr_q;

  always_comb begin
    io_out = 32'd0;
    if (sel && io_rd) begin
      unique case (io_address[3:2])
        2'd0: io_out = {29'd0, ctrl_q};
        2'd1: io_out = load_q;
        2'd2: io_out = count_q;
        2'd3: io_out = {30'd0, ovr_q, pend_q};
        default: io_out = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer_intc.sv
// Self-checking bench for io_timer_intc. Expected values are pushed to a
// scoreboard queue as stimulus is planned and popped when the DUT is sampled.
module tb_io_timer_intc;

  localparam logic [31:0] Base   = 32'h0000_0100;
  localparam logic [31:0] ACtrl  = Base + 32'h0;
  localparam logic [31:0] ALoad  = Base + 32'h4;
  localparam logic [31:0] ACount = Base + 32'h8;
  localparam logic [31:0] AStat  = Base + 32'hC;

  logic        clk;
  logic        reset;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  logic [31:0] io_out;
  logic        intr;
  logic        inta;

  int n_vec;
  int n_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  io_timer_intc #(
    .BASE_ADDR(Base),
    .PRESCALE (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io_cs     (io_cs),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_address(io_address),
    .io_d_in   (io_d_in),
    .io_out    (io_out),
    .intr      (intr),
    .inta      (inta)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_underflow: got %h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_cs      = 1'b1;
    io_wr      = 1'b1;
    io_address = a;
    io_d_in    = d;
    @(negedge clk);
    io_cs = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic rd_cs(input logic cs, input logic [31:0] a);
    io_cs      = cs;
    io_rd      = 1'b1;
    io_address = a;
    #1;
    sb_pop_chk(io_out);
    io_cs = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    rd_cs(1'b1, a);
  endtask

  task automatic intr_chk();
    #1;
    sb_pop_chk({31'd0, intr});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic setup_auto();
    wr(ALoad, 32'd2);
    wr(ACount, 32'd2);
    wr(ACtrl, 32'h7);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b0;
    io_cs      = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    io_address = 32'd0;
    io_d_in    = 32'd0;
    inta       = 1'b0;
    idle(2);
    reset = 1'b1;

    // Reset after random writes
    wr(ALoad, $urandom);
    wr(ACount, $urandom | 32'h100);
    wr(ACtrl, 32'h7);
    idle(3);
    do_reset();
    sb_push("rst_ctrl", 32'h0);
    sb_push("rst_load", 32'h0);
    sb_push("rst_count", 32'h0);
    sb_push("rst_stat", 32'h0);
    sb_push("rst_intr", 32'h0);
    rd(ACtrl);
    rd(ALoad);
    rd(ACount);
    rd(AStat);
    intr_chk();

    // One-shot
    wr(ALoad, 32'd3);
    wr(ACount, 32'd3);
    wr(ACtrl, 32'h5);
    sb_push("os_cnt_e0", 32'd3);
    rd(ACount);
    idle(3);
    sb_push("os_cnt_e3", 32'd3);
    rd(ACount);
    idle(1);
    sb_push("os_cnt_e4", 32'd2);
    rd(ACount);
    idle(4);
    sb_push("os_cnt_e8", 32'd1);
    rd(ACount);
    idle(4);
    sb_push("os_cnt_e12", 32'd0);
    sb_push("os_stat_e12", 32'h1);
    sb_push("os_ctrl_e12", 32'h4);
    sb_push("os_intr_e12", 32'h0);
    rd(ACount);
    rd(AStat);
    rd(ACtrl);
    intr_chk();
    idle(1);
    sb_push("os_intr_e13", 32'h1);
    intr_chk();
    idle(8);
    sb_push("os_cnt_hold", 32'd0);
    rd(ACount);

    // Auto-reload with handshake
    do_reset();
    setup_auto();
    idle(8);
    sb_push("ar_stat_e8", 32'h1);
    sb_push("ar_intr_e8", 32'h0);
    rd(AStat);
    intr_chk();
    idle(1);
    sb_push("ar_intr_e9", 32'h1);
    intr_chk();
    inta = 1'b1;
    idle(1);
    inta = 1'b0;
    sb_push("ar_stat_ack", 32'h0);
    rd(AStat);
    idle(1);
    sb_push("ar_intr_drop", 32'h0);
    intr_chk();
    idle(6);
    sb_push("ar_intr_e17", 32'h1);
    intr_chk();
    inta = 1'b1;
    idle(1);
    inta = 1'b0;
    idle(1);
    sb_push("ar_intr_drop2", 32'h0);
    sb_push("ar_stat_noovr", 32'h0);
    intr_chk();
    rd(AStat);

    // Overrun
    do_reset();
    setup_auto();
    idle(16);
    sb_push("ovr_stat", 32'h3);
    rd(AStat);
    idle(1);
    sb_push("ovr_intr", 32'h1);
    intr_chk();
    wr(AStat, 32'h2);
    sb_push("ovr_clr_stat", 32'h1);
    sb_push("ovr_clr_intr", 32'h1);
    rd(AStat);
    intr_chk();

    // COUNT write on a tick edge
    do_reset();
    wr(ALoad, 32'd0);
    wr(ACount, 32'd5);
    wr(ACtrl, 32'h1);
    idle(3);
    wr(ACount, 32'h10);
    sb_push("col_cnt_wr", 32'h10);
    rd(ACount);
    idle(4);
    sb_push("col_cnt_next", 32'hF);
    rd(ACount);

    // inta on a terminal edge
    do_reset();
    setup_auto();
    idle(15);
    inta = 1'b1;
    idle(1);
    inta = 1'b0;
    sb_push("col_ack_stat", 32'h1);
    sb_push("col_ack_intr", 32'h1);
    rd(AStat);
    intr_chk();
    idle(1);
    sb_push("col_ack_intr2", 32'h1);
    intr_chk();

    // Decode
    do_reset();
    wr(Base + 32'h10, 32'h7);
    wr(Base + 32'h14, 32'hDEAD_BEEF);
    sb_push("dec_ctrl", 32'h0);
    sb_push("dec_load", 32'h0);
    rd(ACtrl);
    rd(ALoad);
    wr(ALoad, 32'h1234);
    sb_push("dec_nocs", 32'h0);
    sb_push("dec_load_ok", 32'h1234);
    rd_cs(1'b0, ALoad);
    rd(ALoad);
    // Read and write together: read shows the pre-write value
    io_cs      = 1'b1;
    io_rd      = 1'b1;
    io_wr      = 1'b1;
    io_address = ALoad;
    io_d_in    = 32'h55;
    sb_push("rw_pre", 32'h1234);
    #1;
    sb_pop_chk(io_out);
    @(negedge clk);
    io_cs = 1'b0;
    io_rd = 1'b0;
    io_wr = 1'b0;
    sb_push("rw_post", 32'h55);
    rd(ALoad);

    // Reset mid-count with intr high
    do_reset();
    setup_auto();
    idle(9);
    sb_push("mid_intr_pre", 32'h1);
    intr_chk();
    do_reset();
    sb_push("mid_ctrl", 32'h0);
    sb_push("mid_load", 32'h0);
    sb_push("mid_count", 32'h0);
    sb_push("mid_stat", 32'h0);
    sb_push("mid_intr", 32'h0);
    rd(ACtrl);
    rd(ALoad);
    rd(ACount);
    rd(AStat);
    intr_chk();
    idle(8);
    sb_push("mid_stat_later", 32'h0);
    sb_push("mid_intr_later", 32'h0);
    rd(AStat);
    intr_chk();

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_leftover: got %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_timer_intc.md
Name: io_timer_intc

Overview:
- Memory-mapped I/O peripheral on the CPU's I/O bus, beside the data memory; shares the address and write-data buses with it.
- A programmable down-counting timer; raises intr toward MIPS_CPU on terminal count.
- Releases intr via the intr/inta handshake.
- Provides the interrupt source the CPU's interrupt entry path consumes.

Parameters:
- BASE_ADDR, 32'h0000_0100: block base address; bits [31:4] compared, block occupies 16 bytes.
- PRESCALE, 4: clk cycles per counter tick, >=1; internal 16-bit prescale counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset, sampled on rising clk.
- io_cs  in  1  I/O chip select from CPU.
- io_rd  in  1  read strobe.
- io_wr  in  1  write strobe.
- io_address  in  32  byte address; [31:4] block select, [3:2] register select, [1:0] ignored.
- io_d_in  in  32  write data.
- io_out  out  32  read data.
- intr  out  1  interrupt request to CPU, level.
- inta  in  1  interrupt acknowledge from CPU.

Behaviour:
- sel = io_cs & (io_address[31:4] == BASE_ADDR[31:4]).
- Register map, offset:
  - 0x0 CTRL: [0] EN, [1] AUTO reload, [2] IE; others read 0.
  - 0x4 LOAD: 32-bit reload value.
  - 0x8 COUNT: current value; a write loads COUNT directly.
  - 0xC STATUS: [0] PEND, [1] OVR; writing 1 to a bit clears it, writing 0 has no effect.
- Reads are combinational, zero latency: io_out = selected register when sel & io_rd, else 32'h0.
- Writes commit at rising clk when sel & io_wr. io_rd and io_wr together: write commits, io_out still shows the pre-write value.
- Reset (reset==0 at clk edge), overrides everything:
  - CTRL=0, LOAD=0, COUNT=0, PEND=0, OVR=0, prescaler=0, intr=0.
  - Reset asserted mid-count or with intr high: all cleared next edge, no event generated.
- Prescaler:
  - Runs only while EN=1: increments each clk; at PRESCALE-1 it wraps to 0 and emits a one-cycle tick.
  - EN=0 holds the prescaler at 0. Writing CTRL always zeroes the prescaler.
- Counter, on tick:
  - COUNT>1: COUNT-1.
  - COUNT==1: COUNT becomes LOAD if AUTO=1, else 0 with EN cleared. Terminal event fires.
  - COUNT==0 with EN=1 (e.g. LOAD=0 reload): terminal event fires every tick; COUNT stays 0 (AUTO) or EN clears.
  - Down-count only; no wrap below 0.
- Terminal event: if PEND already 1, set OVR; then set PEND=1.
- intr: registered, intr = PEND & IE, updated each edge. Clearing IE drops intr next cycle while PEND is kept.
- inta handshake:
  - inta==1 at a clk edge with intr==1 clears PEND; intr falls the following cycle.
  - inta while intr==0 is ignored.
  - inta held for multiple cycles clears only the currently pending event once per edge; a new event on the same edge as inta wins, leaving PEND=1 and OVR unchanged.
- Same-edge priority, highest first: reset > CPU register write > terminal event > inta clear.
  - A COUNT write on a tick edge: written value taken, no decrement.
  - A STATUS write-1 to PEND on an event edge: PEND stays 1.

Test Plan:
- Reset check: reset=0 for 1 edge after random writes -> all reads 0, intr=0.
- One-shot: LOAD=3, write COUNT=3, CTRL=0x5, PRESCALE=4 -> COUNT reads 2,1,0 at 4-cycle intervals; PEND=1 and EN=0 after the 12th cycle; intr high one cycle later; COUNT stays 0.
- Auto-reload + handshake: LOAD=2, COUNT=2, CTRL=0x7 -> intr every 8 cycles; pulsing inta one cycle per event drops intr the next cycle; OVR stays 0.
- Overrun: same setup as auto-reload, no inta -> second terminal event sets STATUS=0x3; writing STATUS=0x2 -> 0x1, intr still 1.
- Same-edge collisions: (a) COUNT write 0x10 on a tick edge -> COUNT reads 0x10; (b) inta on a terminal edge -> PEND stays 1, intr stays 1.
- Decode and reset mid-operation: write at BASE_ADDR+0x10 -> no register change; io_cs=0 reads -> io_out=0; reset mid-count with intr high -> all cleared next edge.
